// File: rtl/nibble_acc_pkg.sv
// Shared definitions for the nibble accumulator control stage: operand width,
// command op codes and the controller state encoding.
package nibble_acc_pkg;

    localparam int unsigned NIBBLE_W = 4;

    // Command op codes carried on in_op
    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SUB   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE
    } state_e;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter with a done flag. Used to hold off a capture while a
// multi-cycle combinational path (e.g. a ripple-carry chain) settles.
module settle_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load has priority; otherwise count down and stop at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/nibble_accumulator_ctrl.sv
// Control stage around an external 4-bit ripple-carry adder. Accepts nibble
// commands over valid/ready, drives the adder operands, waits SETTLE_CYCLES for
// the chain to settle, then captures sum/carry into the accumulator.
// Optional feature macro: ACC_SUBTRACT_EN (op 11 becomes SUB; otherwise no-op).
module nibble_accumulator_ctrl
    import nibble_acc_pkg::*;
#(
    parameter int unsigned         SETTLE_CYCLES = 2,
    parameter logic [NIBBLE_W-1:0] ACC_RESET_VAL = 4'h0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [NIBBLE_W-1:0] in_data,
    output logic [NIBBLE_W-1:0] add_a,
    output logic [NIBBLE_W-1:0] add_b,
    output logic                add_cin,
    input  logic [NIBBLE_W-1:0] add_s,
    input  logic                add_cout,
    output logic [NIBBLE_W-1:0] acc,
    output logic                carry,
    output logic                ovf,
    output logic                res_valid,
    output logic                busy
);

    if ((SETTLE_CYCLES == 0) || (SETTLE_CYCLES > 15)) begin : g_settle_range_check
        $error("nibble_accumulator_ctrl: SETTLE_CYCLES must be in 1..15");
    end

    localparam logic [NIBBLE_W-1:0] SETTLE_LOAD = NIBBLE_W'(SETTLE_CYCLES - 1);

    state_e              state_q, state_d;
    logic [NIBBLE_W-1:0] acc_q, acc_d;
    logic [NIBBLE_W-1:0] add_a_q, add_a_d;
    logic [NIBBLE_W-1:0] add_b_q, add_b_d;
    logic                add_cin_q, add_cin_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic                res_valid_q, res_valid_d;
    logic                tmr_load, tmr_en, tmr_done;
    logic                accept;

    assign in_ready = (state_q == ST_IDLE) && !RST;
    assign accept   = in_valid && in_ready;

    settle_timer #(
        .CNT_W (NIBBLE_W)
    ) u_settle_timer (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (tmr_load),
        .load_val_i (SETTLE_LOAD),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    // Next-state, operand and result logic.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        add_cin_d   = add_cin_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        res_valid_d = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (in_op)
                        OP_LOAD: begin
                            acc_d       = in_data;
                            carry_d     = 1'b0;
                            ovf_d       = 1'b0;
                            res_valid_d = 1'b1;
                        end
                        OP_CLEAR: begin
                            acc_d       = ACC_RESET_VAL;
                            carry_d     = 1'b0;
                            ovf_d       = 1'b0;
                            res_valid_d = 1'b1;
                        end
                        OP_ADD: begin
                            add_a_d   = acc_q;
                            add_b_d   = in_data;
                            add_cin_d = 1'b0;
                            tmr_load  = 1'b1;
                            state_d   = ST_SETTLE;
                        end
                        default: begin
`ifdef ACC_SUBTRACT_EN
                            // Two's-complement subtract through the same adder.
                            add_a_d   = acc_q;
                            add_b_d   = ~in_data;
                            add_cin_d = 1'b1;
                            tmr_load  = 1'b1;
                            state_d   = ST_SETTLE;
`else
                            // Accepted no-op: only acknowledge.
                            res_valid_d = 1'b1;
`endif
                        end
                    endcase
                end
            end
            ST_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_done) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                acc_d       = add_s;
                carry_d     = add_cout;
`ifdef ACC_SUBTRACT_EN
                // cin=1 marks a subtract, where a missing carry means borrow.
                ovf_d       = ovf_q | (add_cin_q ? ~add_cout : add_cout);
`else
                ovf_d       = ovf_q | add_cout;
`endif
                res_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            acc_q       <= ACC_RESET_VAL;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_cin_q   <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_cin_q   <= add_cin_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_cin   = add_cin_q;
    assign acc       = acc_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nibble_accumulator_ctrl.sv
// Bench for nibble_accumulator_ctrl: three instances (SETTLE_CYCLES 2, 1, 15),
// each with its own behavioural 4-bit adder. Honours ACC_SUBTRACT_EN if defined.
module tb_nibble_accumulator_ctrl;
    import nibble_acc_pkg::*;

    logic       CLK;
    logic       RST;
    logic [2:0] in_valid, in_ready, add_cin, add_cout, carry, ovf, res_valid, busy;
    logic [1:0] in_op   [3];
    logic [3:0] in_data [3];
    logic [3:0] add_a   [3];
    logic [3:0] add_b   [3];
    logic [3:0] add_s   [3];
    logic [3:0] acc     [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned SC = (g == 0) ? 2 : ((g == 1) ? 1 : 15);
        nibble_accumulator_ctrl #(
            .SETTLE_CYCLES (SC),
            .ACC_RESET_VAL (4'h0)
        ) u_dut (
            .CLK       (CLK),
            .RST       (RST),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_op     (in_op[g]),
            .in_data   (in_data[g]),
            .add_a     (add_a[g]),
            .add_b     (add_b[g]),
            .add_cin   (add_cin[g]),
            .add_s     (add_s[g]),
            .add_cout  (add_cout[g]),
            .acc       (acc[g]),
            .carry     (carry[g]),
            .ovf       (ovf[g]),
            .res_valid (res_valid[g]),
            .busy      (busy[g])
        );
        // Behavioural ripple-carry adder
        assign {add_cout[g], add_s[g]} = {1'b0, add_a[g]} + {1'b0, add_b[g]} + {4'b0, add_cin[g]};
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] acc;
        logic       carry;
        logic       ovf;
    } vec_t;

    vec_t vecs [16];
    int   nv = 0;

    task automatic add_vec(input logic [1:0] op, input logic [3:0] data, input logic [3:0] a,
                           input logic c, input logic o);
        vecs[nv] = '{op, data, a, c, o};
        nv++;
    endtask

    function automatic bit is_multi(input logic [1:0] op);
`ifdef ACC_SUBTRACT_EN
        return (op == OP_ADD) || (op == OP_SUB);
`else
        return (op == OP_ADD);
`endif
    endfunction

    // Issue one command at a negedge, wait for the res_valid pulse (bounded),
    // capture results, then confirm the pulse lasts one cycle. Ends on a negedge.
    task automatic do_cmd(input int d, input logic [1:0] op, input logic [3:0] data,
                          output int lat, output int notready,
                          output logic [3:0] r_acc, output logic r_carry, output logic r_ovf);
        int w;
        w = 0;
        while (!in_ready[d] && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (!in_ready[d]) check("ready_timeout", {31'b0, in_ready[d]}, 1);
        in_valid[d] = 1'b1;
        in_op[d]    = op;
        in_data[d]  = data;
        @(posedge CLK);
        @(negedge CLK);
        in_valid[d] = 1'b0;
        lat      = 0;
        notready = 0;
        while (!res_valid[d] && lat < 40) begin
            if (!in_ready[d]) notready++;
            @(negedge CLK);
            lat++;
        end
        check("res_valid_seen", {31'b0, res_valid[d]}, 1);
        r_acc   = acc[d];
        r_carry = carry[d];
        r_ovf   = ovf[d];
        @(negedge CLK);
        check("res_valid_single", {31'b0, res_valid[d]}, 0);
    endtask

    int         lat, nrdy, pulses, two_row, phase;
    logic       prev, b_ok, c, o;
    logic [3:0] a;

    initial begin
        RST      = 1'b1;
        in_valid = '0;
        for (int i = 0; i < 3; i++) begin
            in_op[i]   = OP_LOAD;
            in_data[i] = 4'h0;
        end

        // Reset state
        @(negedge CLK);
        @(negedge CLK);
        check("rst_acc",       {28'b0, acc[0]}, 0);
        check("rst_carry",     {31'b0, carry[0]}, 0);
        check("rst_ovf",       {31'b0, ovf[0]}, 0);
        check("rst_res_valid", {31'b0, res_valid[0]}, 0);
        check("rst_in_ready",  {31'b0, in_ready[0]}, 0);
        check("rst_busy",      {31'b0, busy[0]}, 0);
        check("rst_add_a",     {28'b0, add_a[0]}, 0);
        check("rst_add_b",     {28'b0, add_b[0]}, 0);
        check("rst_add_cin",   {31'b0, add_cin[0]}, 0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_in_ready", {31'b0, in_ready[0]}, 1);

        // Directed vector table
        add_vec(OP_LOAD,  4'h5, 4'h5, 1'b0, 1'b0);
        add_vec(OP_ADD,   4'h3, 4'h8, 1'b0, 1'b0);
        add_vec(OP_ADD,   4'h9, 4'h1, 1'b1, 1'b1);
        add_vec(OP_ADD,   4'h2, 4'h3, 1'b0, 1'b1);
        add_vec(OP_CLEAR, 4'h0, 4'h0, 1'b0, 1'b0);
        add_vec(OP_LOAD,  4'hF, 4'hF, 1'b0, 1'b0);
        add_vec(OP_ADD,   4'h1, 4'h0, 1'b1, 1'b1);
`ifdef ACC_SUBTRACT_EN
        add_vec(OP_SUB,   4'h5, 4'hB, 1'b0, 1'b1);
        add_vec(OP_LOAD,  4'h3, 4'h3, 1'b0, 1'b0);
        add_vec(OP_SUB,   4'h5, 4'hE, 1'b0, 1'b1);
        add_vec(OP_LOAD,  4'h9, 4'h9, 1'b0, 1'b0);
        add_vec(OP_SUB,   4'h4, 4'h5, 1'b1, 1'b0);
`else
        add_vec(OP_SUB,   4'h5, 4'h0, 1'b1, 1'b1);
        add_vec(OP_LOAD,  4'h3, 4'h3, 1'b0, 1'b0);
        add_vec(OP_SUB,   4'h5, 4'h3, 1'b0, 1'b0);
        add_vec(OP_LOAD,  4'h9, 4'h9, 1'b0, 1'b0);
        add_vec(OP_SUB,   4'h4, 4'h9, 1'b0, 1'b0);
`endif
        add_vec(OP_CLEAR, 4'h7, 4'h0, 1'b0, 1'b0);

        for (int i = 0; i < nv; i++) begin
            do_cmd(0, vecs[i].op, vecs[i].data, lat, nrdy, a, c, o);
            check($sformatf("vec%0d_acc", i),   {28'b0, a}, {28'b0, vecs[i].acc});
            check($sformatf("vec%0d_carry", i), {31'b0, c}, {31'b0, vecs[i].carry});
            check($sformatf("vec%0d_ovf", i),   {31'b0, o}, {31'b0, vecs[i].ovf});
            if (is_multi(vecs[i].op)) begin
                check($sformatf("vec%0d_latency", i), lat, 3);
                check($sformatf("vec%0d_not_ready_cycles", i), nrdy, 3);
            end else begin
                check($sformatf("vec%0d_latency", i), lat, 0);
            end
        end

        // in_valid held during SETTLE: second ADD waits for in_ready
        do_cmd(0, OP_LOAD, 4'h1, lat, nrdy, a, c, o);
        in_valid[0] = 1'b1;
        in_op[0]    = OP_ADD;
        in_data[0]  = 4'h2;
        pulses = 0; two_row = 0; phase = 0; prev = 1'b0; b_ok = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (phase == 1) begin
                in_valid[0] = 1'b0;
                phase = 2;
            end
            if (res_valid[0]) pulses++;
            if (res_valid[0] && prev) two_row++;
            prev = res_valid[0];
            if (phase == 0) begin
                in_data[0] = 4'h3;
                if (busy[0] && add_b[0] != 4'h2) b_ok = 1'b0;
                if (in_ready[0]) phase = 1;
            end
        end
        in_valid[0] = 1'b0;
        check("held_valid_pulses",       pulses, 2);
        check("held_valid_two_in_row",   two_row, 0);
        check("held_valid_operand_hold", {31'b0, b_ok}, 1);
        check("held_valid_accepted",     phase, 2);
        check("held_valid_acc",          {28'b0, acc[0]}, 6);

        // Reset pulsed mid-SETTLE aborts the ADD
        do_cmd(0, OP_LOAD, 4'h4, lat, nrdy, a, c, o);
        in_valid[0] = 1'b1;
        in_op[0]    = OP_ADD;
        in_data[0]  = 4'h5;
        @(posedge CLK);
        @(negedge CLK);
        in_valid[0] = 1'b0;
        check("abort_busy_before", {31'b0, busy[0]}, 1);
        check("abort_add_b_before", {28'b0, add_b[0]}, 5);
        #1 RST = 1'b1;
        #1;
        check("abort_acc",      {28'b0, acc[0]}, 0);
        check("abort_add_a",    {28'b0, add_a[0]}, 0);
        check("abort_add_b",    {28'b0, add_b[0]}, 0);
        check("abort_busy",     {31'b0, busy[0]}, 0);
        check("abort_in_ready", {31'b0, in_ready[0]}, 0);
        @(negedge CLK);
        RST = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (res_valid[0]) pulses++;
        end
        check("abort_no_res_valid", pulses, 0);
        do_cmd(0, OP_LOAD, 4'h7, lat, nrdy, a, c, o);
        check("post_reset_load_acc", {28'b0, a}, 7);

        // Latency at SETTLE_CYCLES = 1 and 15
        do_cmd(1, OP_LOAD, 4'h0, lat, nrdy, a, c, o);
        do_cmd(1, OP_ADD, 4'h1, lat, nrdy, a, c, o);
        check("settle1_latency", lat, 2);
        check("settle1_acc", {28'b0, a}, 1);
        do_cmd(2, OP_LOAD, 4'h0, lat, nrdy, a, c, o);
        do_cmd(2, OP_ADD, 4'h1, lat, nrdy, a, c, o);
        check("settle15_latency", lat, 16);
        check("settle15_not_ready_cycles", nrdy, 16);
        check("settle15_acc", {28'b0, a}, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nibble_accumulator_ctrl.md
Name: nibble_accumulator_ctrl

Overview:
- Sequential control stage wrapped around the 4-bit ripple-carry adder.
- Upstream role: drives the adder's operand and carry-in inputs.
- Downstream role: captures the adder's sum and carry-out into a 4-bit accumulator.
- Accepts nibble commands over a valid/ready handshake, for example from keypad or switch logic.
- Waits a programmable number of cycles for the ripple chain to settle, then registers the result and flags for the display logic.

Parameters:
- SETTLE_CYCLES, default 2: cycles the operands are held stable before the sum is captured. Legal range 1..15; 0 is illegal and is flagged by an elaboration-time check.
- ACC_RESET_VAL, default 4'h0: accumulator value after reset and after a CLEAR command.

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-high reset
- in_valid  input  1  command/data valid
- in_ready  output  1  block can accept a command this cycle
- in_op  input  2  command: 00 LOAD, 01 ADD, 10 CLEAR, 11 SUB
- in_data  input  4  operand nibble
- add_a  output  4  to adder A3..A0
- add_b  output  4  to adder B3..B0
- add_cin  output  1  to adder Cin
- add_s  input  4  from adder S3..S0
- add_cout  input  1  from adder Cout
- acc  output  4  accumulator value
- carry  output  1  carry-out of the last ADD/SUB
- ovf  output  1  sticky unsigned overflow
- res_valid  output  1  one-cycle pulse when acc/carry have been updated
- busy  output  1  high in SETTLE and CAPTURE states

Behaviour:
- Reset (async, RST=1): state=IDLE, acc=ACC_RESET_VAL, carry=0, ovf=0, res_valid=0, add_a=0, add_b=0, add_cin=0, settle counter=0.
- Release from reset is synchronous to CLK.
- States: IDLE, SETTLE, CAPTURE.
- in_ready = (state==IDLE) && !RST. busy = (state!=IDLE).
- A command is accepted on a rising edge where in_valid && in_ready.
- IDLE, LOAD: acc<=in_data; carry<=0; ovf<=0; res_valid pulses in the next cycle; remain in IDLE. Latency 1.
- IDLE, CLEAR: acc<=ACC_RESET_VAL; carry<=0; ovf<=0; res_valid pulses in the next cycle; remain in IDLE.
- IDLE, ADD: add_a<=acc, add_b<=in_data, add_cin<=0; counter<=SETTLE_CYCLES-1; go to SETTLE.
- SETTLE: add_a, add_b and add_cin are held constant. Decrement the counter; when counter==0, go to CAPTURE.
- CAPTURE: acc<=add_s; carry<=add_cout; ovf<=ovf | add_cout; res_valid pulses in the next cycle; go to IDLE.
- ADD latency: acceptance edge to res_valid high is SETTLE_CYCLES+1 cycles. The next command can be accepted SETTLE_CYCLES+1 cycles after acceptance.
- The operand registers keep their last value in IDLE; they are not cleared.
- res_valid is high for exactly one cycle per accepted command, never two in a row.
- in_valid while busy: ignored, no queuing. The source must hold it until in_ready.
- in_op=11 without the feature: treated as a no-op. Accepted, acc unchanged, res_valid still pulses.
- Arithmetic is modulo 16. carry is the adder's Cout verbatim.
- RST asserted mid-SETTLE/CAPTURE: the operation is aborted and all reset values apply immediately. No res_valid is produced.

Optional Feature:
- Macro ACC_SUBTRACT_EN.
- Defined: op 11 = SUB. add_a<=acc, add_b<=~in_data, add_cin<=1; same SETTLE/CAPTURE path.
- SUB result: carry=1 means no borrow. ovf is set when carry==0 (borrow).
- Not defined: op 11 is the no-op described in Behaviour, and the inversion logic is absent.

Decomposition:
- Shared package nibble_acc_pkg:
  - op code constants: OP_LOAD, OP_ADD, OP_CLEAR, OP_SUB
  - state enum: ST_IDLE, ST_SETTLE, ST_CAPTURE
  - NIBBLE_W=4
- One natural sub-module: settle_timer. A loadable down-counter with a done flag, reusable by other multi-cycle combinational stages.
- The adder itself stays external. The bench and top level connect it.

Test Plan (bench instantiates the 4-bit adder model; SETTLE_CYCLES=2 unless noted):
- LOAD 5 then ADD 3 -> acc=8, carry=0, ovf=0. res_valid 3 cycles after ADD acceptance; in_ready low for 3 cycles.
- acc=8, ADD 9 -> acc=1, carry=1, ovf=1. Then ADD 2 -> acc=3, carry=0, ovf stays 1. Then CLEAR -> acc=0, ovf=0.
- in_valid held high with a new ADD during SETTLE -> not accepted until in_ready returns; exactly one res_valid per command.
- RST pulsed in SETTLE after ADD -> all outputs return to reset values asynchronously; no res_valid; first post-reset LOAD 7 -> acc=7.
- SETTLE_CYCLES=1 and 15: ADD latency measured as 2 and 16 cycles respectively.
- With ACC_SUBTRACT_EN: LOAD 3, SUB 5 -> acc=4'hE, carry=0, ovf=1. LOAD 9, SUB 4 -> acc=5, carry=1, ovf=0.
